// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// State enum, mux-select encodings, ALU codes and data-processing cmd values.
package mc_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned RD_W    = 4;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_EOR = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_ROR = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_MOV = 3'b100;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] IMM_DP  = 2'b00;
    localparam logic [SEL_W-1:0] IMM_MEM = 2'b01;
    localparam logic [SEL_W-1:0] IMM_BR  = 2'b10;

    localparam logic [OP_W-1:0] OP_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_BR  = 2'b10;

    localparam logic [CMD_W-1:0] CMD_ADD    = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SUB    = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_CMP    = 4'b1010;
    localparam logic [CMD_W-1:0] CMD_EOR    = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MOVROR = 4'b1101;

    localparam logic [RD_W-1:0] RD_PC = 4'b1111;

    // Carry/overflow flags are only meaningful for the adder operations.
    function automatic logic is_arith(input logic [ALUC_W-1:0] aluc);
        return (aluc == ALU_ADD) || (aluc == ALU_SUB);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Data-processing decode: Funct -> ALUControl, raw FlagW and writeback suppression.
// FlagW here is not yet qualified by the condition check.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [FUNCT_W-1:0] i_funct,
    output logic [ALUC_W-1:0]  o_alu_control,
    output logic [SEL_W-1:0]   o_flag_w,
    output logic               o_no_write
);

    logic             w_imm;
    logic [CMD_W-1:0] w_cmd;
    logic             w_s;

    assign w_imm = i_funct[5];
    assign w_cmd = i_funct[4:1];
    assign w_s   = i_funct[0];

    always_comb begin
        o_alu_control = ALU_ADD;
        o_no_write    = 1'b0;
        case (w_cmd)
            CMD_ADD:    o_alu_control = ALU_ADD;
            CMD_SUB:    o_alu_control = ALU_SUB;
            CMD_CMP: begin
                o_alu_control = ALU_SUB;
                o_no_write    = 1'b1;
            end
            CMD_EOR:    o_alu_control = ALU_EOR;
            CMD_MOVROR: o_alu_control = w_imm ? ALU_MOV : ALU_ROR;
            // Unsupported commands run as a flag-only ADD.
            default:    o_no_write    = 1'b1;
        endcase
        o_flag_w = {w_s, w_s & is_arith(o_alu_control)};
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM driving the shared ALU / unified memory datapath.
// Optional MC_MEM_WAIT_EN adds MemReady wait states in FETCH, MEMRD and MEMWR.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Op,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [RD_W-1:0]    Rd,
    input  logic               CondEx,
`ifdef MC_MEM_WAIT_EN
    input  logic               MemReady,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemW,
    output logic               IRWrite,
    output logic               RegW,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic               ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   ImmSrc,
    output logic [SEL_W-1:0]   RegSrc,
    output logic [ALUC_W-1:0]  ALUControl,
    output logic [SEL_W-1:0]   FlagW,
    output logic               Illegal
);

    state_t              r_state;
    state_t              w_next;
    logic                w_mem_ready;
    logic                w_rd_pc;
    logic [ALUC_W-1:0]   w_alu_control;
    logic [SEL_W-1:0]    w_flag_w_pre;
    logic                w_no_write;

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_rd_pc = (Rd == RD_PC);

    mc_alu_dec u_alu_dec (
        .i_funct       (Funct),
        .o_alu_control (w_alu_control),
        .o_flag_w      (w_flag_w_pre),
        .o_no_write    (w_no_write)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next state and Moore outputs; every write enable is masked during reset.
    always_comb begin
        w_next     = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_DP;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        Illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = w_mem_ready;
                PCWrite   = w_mem_ready;
                w_next    = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:  w_next = S_MEMADR;
                    OP_DP:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   w_next = S_BRANCH;
                    default: begin
                        Illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_MEM;
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = CondEx;
                PCWrite   = CondEx & w_rd_pc;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = CondEx;
                RegSrc = 2'b10;
                w_next = w_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                ImmSrc     = IMM_DP;
                ALUControl = w_alu_control;
                FlagW      = w_flag_w_pre & {SEL_W{CondEx}};
                w_next     = w_no_write ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegW      = CondEx;
                PCWrite   = CondEx & w_rd_pc;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_BR;
                RegSrc    = 2'b01;
                ResultSrc = RES_ALURESULT;
                PCWrite   = CondEx;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        if (reset) begin
            PCWrite = 1'b0;
            IRWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            FlagW   = 2'b00;
            Illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus reset / wait-state sequences.
// Build with MC_MEM_WAIT_EN defined to include the MemReady sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
`ifdef MC_MEM_WAIT_EN
    logic       MemReady;
`endif
    logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, Illegal;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .CondEx     (CondEx),
`ifdef MC_MEM_WAIT_EN
        .MemReady   (MemReady),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemW       (MemW),
        .IRWrite    (IRWrite),
        .RegW       (RegW),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .Illegal    (Illegal)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rs;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [2:0] aluc;
        logic [1:0] flagw;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       cond;
        outs_t      exp;
    } vec_t;

    vec_t  vecs[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t E_F, E_D, E_RST, E_DILL, E_MADR, E_MRD;

    function automatic outs_t mk(input logic pcw, adr, memw, irw, regw,
                                 input logic [1:0] rs, input logic srca,
                                 input logic [1:0] srcb, imm, regsrc,
                                 input logic [2:0] aluc, input logic [1:0] flagw,
                                 input logic ill);
        outs_t o;
        o.pcw = pcw; o.adr = adr; o.memw = memw; o.irw = irw; o.regw = regw;
        o.rs = rs; o.srca = srca; o.srcb = srcb; o.imm = imm; o.regsrc = regsrc;
        o.aluc = aluc; o.flagw = flagw; o.ill = ill;
        return o;
    endfunction

    function automatic outs_t exr(input logic [2:0] a, input logic [1:0] f);
        return mk(0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, a, f, 0);
    endfunction
    function automatic outs_t exi(input logic [2:0] a, input logic [1:0] f);
        return mk(0,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 2'b00, a, f, 0);
    endfunction
    function automatic outs_t aluwb(input logic r, input logic p);
        return mk(p,0,0,0,r, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t memwb(input logic r, input logic p);
        return mk(p,0,0,0,r, 2'b01, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t memwr(input logic m);
        return mk(0,1,m,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t branch(input logic p);
        return mk(p,0,0,0,0, 2'b10, 0, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0);
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a.pcw = PCWrite; a.adr = AdrSrc; a.memw = MemW; a.irw = IRWrite; a.regw = RegW;
        a.rs = ResultSrc; a.srca = ALUSrcA; a.srcb = ALUSrcB; a.imm = ImmSrc;
        a.regsrc = RegSrc; a.aluc = ALUControl; a.flagw = FlagW; a.ill = Illegal;
        return a;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (pcw,adr,memw,irw,regw,rs,srca,srcb,imm,regsrc,aluc,flagw,ill)",
                     name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic cond, input outs_t exp);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct; v.rd = rd; v.cond = cond; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic cond);
        Op = op; Funct = funct; Rd = rd; CondEx = cond;
    endtask

    // Check mid-cycle, then advance to the next falling edge.
    task automatic cyc(input string name, input outs_t exp);
        #1 check(name, exp);
        @(negedge clk);
    endtask

    initial begin
        E_F    = mk(1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        E_D    = mk(0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        E_RST  = mk(0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        E_DILL = mk(0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        E_MADR = mk(0,0,0,0,0, 2'b00, 0, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 0);
        E_MRD  = mk(0,1,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);

        add("ADD.F",   2'b00, 6'b001000, 4'd1, 1, E_F);
        add("ADD.D",   2'b00, 6'b001000, 4'd1, 1, E_D);
        add("ADD.EX",  2'b00, 6'b001000, 4'd1, 1, exr(3'b000, 2'b00));
        add("ADD.WB",  2'b00, 6'b001000, 4'd1, 1, aluwb(1, 0));
        add("SUBSI.F", 2'b00, 6'b100101, 4'd2, 1, E_F);
        add("SUBSI.D", 2'b00, 6'b100101, 4'd2, 1, E_D);
        add("SUBSI.EX",2'b00, 6'b100101, 4'd2, 1, exi(3'b001, 2'b11));
        add("SUBSI.WB",2'b00, 6'b100101, 4'd2, 1, aluwb(1, 0));
        add("CMP.F",   2'b00, 6'b110101, 4'd0, 1, E_F);
        add("CMP.D",   2'b00, 6'b110101, 4'd0, 1, E_D);
        add("CMP.EX",  2'b00, 6'b110101, 4'd0, 1, exi(3'b001, 2'b11));
        add("ADDS.F",  2'b00, 6'b001001, 4'd5, 1, E_F);
        add("ADDS.D",  2'b00, 6'b001001, 4'd5, 1, E_D);
        add("ADDS.EX", 2'b00, 6'b001001, 4'd5, 1, exr(3'b000, 2'b11));
        add("ADDS.WB", 2'b00, 6'b001001, 4'd5, 1, aluwb(1, 0));
        add("EORS.F",  2'b00, 6'b000011, 4'd6, 1, E_F);
        add("EORS.D",  2'b00, 6'b000011, 4'd6, 1, E_D);
        add("EORS.EX", 2'b00, 6'b000011, 4'd6, 1, exr(3'b010, 2'b10));
        add("EORS.WB", 2'b00, 6'b000011, 4'd6, 1, aluwb(1, 0));
        add("EORnc.F", 2'b00, 6'b000011, 4'd6, 0, E_F);
        add("EORnc.D", 2'b00, 6'b000011, 4'd6, 0, E_D);
        add("EORnc.EX",2'b00, 6'b000011, 4'd6, 0, exr(3'b010, 2'b00));
        add("EORnc.WB",2'b00, 6'b000011, 4'd6, 0, aluwb(0, 0));
        add("MOVI.F",  2'b00, 6'b111010, 4'd7, 1, E_F);
        add("MOVI.D",  2'b00, 6'b111010, 4'd7, 1, E_D);
        add("MOVI.EX", 2'b00, 6'b111010, 4'd7, 1, exi(3'b100, 2'b00));
        add("MOVI.WB", 2'b00, 6'b111010, 4'd7, 1, aluwb(1, 0));
        add("ROR.F",   2'b00, 6'b011010, 4'd8, 1, E_F);
        add("ROR.D",   2'b00, 6'b011010, 4'd8, 1, E_D);
        add("ROR.EX",  2'b00, 6'b011010, 4'd8, 1, exr(3'b011, 2'b00));
        add("ROR.WB",  2'b00, 6'b011010, 4'd8, 1, aluwb(1, 0));
        add("AND.F",   2'b00, 6'b000000, 4'd9, 1, E_F);
        add("AND.D",   2'b00, 6'b000000, 4'd9, 1, E_D);
        add("AND.EX",  2'b00, 6'b000000, 4'd9, 1, exr(3'b000, 2'b00));
        add("ADDpc.F", 2'b00, 6'b001000, 4'd15, 1, E_F);
        add("ADDpc.D", 2'b00, 6'b001000, 4'd15, 1, E_D);
        add("ADDpc.EX",2'b00, 6'b001000, 4'd15, 1, exr(3'b000, 2'b00));
        add("ADDpc.WB",2'b00, 6'b001000, 4'd15, 1, aluwb(1, 1));
        add("ADDpcn.F",2'b00, 6'b001000, 4'd15, 0, E_F);
        add("ADDpcn.D",2'b00, 6'b001000, 4'd15, 0, E_D);
        add("ADDpcn.EX",2'b00,6'b001000, 4'd15, 0, exr(3'b000, 2'b00));
        add("ADDpcn.WB",2'b00,6'b001000, 4'd15, 0, aluwb(0, 0));
        add("LDR.F",   2'b01, 6'b011001, 4'd3, 1, E_F);
        add("LDR.D",   2'b01, 6'b011001, 4'd3, 1, E_D);
        add("LDR.ADR", 2'b01, 6'b011001, 4'd3, 1, E_MADR);
        add("LDR.RD",  2'b01, 6'b011001, 4'd3, 1, E_MRD);
        add("LDR.WB",  2'b01, 6'b011001, 4'd3, 1, memwb(1, 0));
        add("LDRnc.F", 2'b01, 6'b011001, 4'd3, 0, E_F);
        add("LDRnc.D", 2'b01, 6'b011001, 4'd3, 0, E_D);
        add("LDRnc.ADR",2'b01,6'b011001, 4'd3, 0, E_MADR);
        add("LDRnc.RD",2'b01, 6'b011001, 4'd3, 0, E_MRD);
        add("LDRnc.WB",2'b01, 6'b011001, 4'd3, 0, memwb(0, 0));
        add("LDRpc.F", 2'b01, 6'b011001, 4'd15, 1, E_F);
        add("LDRpc.D", 2'b01, 6'b011001, 4'd15, 1, E_D);
        add("LDRpc.ADR",2'b01,6'b011001, 4'd15, 1, E_MADR);
        add("LDRpc.RD",2'b01, 6'b011001, 4'd15, 1, E_MRD);
        add("LDRpc.WB",2'b01, 6'b011001, 4'd15, 1, memwb(1, 1));
        add("STR.F",   2'b01, 6'b011000, 4'd4, 1, E_F);
        add("STR.D",   2'b01, 6'b011000, 4'd4, 1, E_D);
        add("STR.ADR", 2'b01, 6'b011000, 4'd4, 1, E_MADR);
        add("STR.WR",  2'b01, 6'b011000, 4'd4, 1, memwr(1));
        add("STRnc.F", 2'b01, 6'b011000, 4'd4, 0, E_F);
        add("STRnc.D", 2'b01, 6'b011000, 4'd4, 0, E_D);
        add("STRnc.ADR",2'b01,6'b011000, 4'd4, 0, E_MADR);
        add("STRnc.WR",2'b01, 6'b011000, 4'd4, 0, memwr(0));
        add("B.F",     2'b10, 6'b000000, 4'd0, 1, E_F);
        add("B.D",     2'b10, 6'b000000, 4'd0, 1, E_D);
        add("B.BR",    2'b10, 6'b000000, 4'd0, 1, branch(1));
        add("Bnc.F",   2'b10, 6'b000000, 4'd0, 0, E_F);
        add("Bnc.D",   2'b10, 6'b000000, 4'd0, 0, E_D);
        add("Bnc.BR",  2'b10, 6'b000000, 4'd0, 0, branch(0));
        add("ILL.F",   2'b11, 6'b000000, 4'd0, 1, E_F);
        add("ILL.D",   2'b11, 6'b000000, 4'd0, 1, E_DILL);

        reset = 1'b1;
        drive(2'b00, 6'b000000, 4'd0, 1'b0);
`ifdef MC_MEM_WAIT_EN
        MemReady = 1'b1;
`endif
        @(negedge clk);
        #1 check("in_reset", E_RST);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].cond);
            cyc(vecs[i].name, vecs[i].exp);
        end

        // Reset during an ALU writeback to the PC: both writes must vanish at once.
        drive(2'b00, 6'b001000, 4'd15, 1'b1);
        cyc("rstA.F", E_F);
        cyc("rstA.D", E_D);
        cyc("rstA.EX", exr(3'b000, 2'b00));
        #1 check("rstA.WB", aluwb(1, 1));
        #2 reset = 1'b1;
        #1 check("rstA.in_reset", E_RST);
        @(negedge clk);
        reset = 1'b0;

        // Reset during a store: MemW drops immediately and the next cycle fetches.
        drive(2'b01, 6'b011000, 4'd4, 1'b1);
        cyc("rstS.F", E_F);
        cyc("rstS.D", E_D);
        cyc("rstS.ADR", E_MADR);
        #1 check("rstS.WR", memwr(1));
        #2 reset = 1'b1;
        #1 check("rstS.in_reset", E_RST);
        @(negedge clk);
        reset = 1'b0;
        cyc("rstS.after_F", E_F);
        cyc("rstS.after_D", E_D);

`ifdef MC_MEM_WAIT_EN
        // Store completes through two wait cycles with MemW held.
        cyc("wait.ADR", E_MADR);
        MemReady = 1'b0;
        cyc("wait.WR0", memwr(1));
        cyc("wait.WR1", memwr(1));
        MemReady = 1'b1;
        cyc("wait.WR2", memwr(1));
        // Fetch stalls three cycles, then pulses IRWrite/PCWrite once.
        MemReady = 1'b0;
        for (int k = 0; k < 3; k++)
            cyc("wait.F_stall", mk(0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        MemReady = 1'b1;
        cyc("wait.F_go", E_F);
        cyc("wait.D", E_D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the ARM-subset core. Sequences fetch, decode, execute, memory and writeback over multiple cycles so that a single shared ALU and a unified instruction/data memory port can be reused across each instruction. Sits between the instruction register (Op/Funct/Rd fields), the conditional-execution logic (CondEx) and the shared datapath, whose muxes and write enables it drives every cycle.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH immediately.
- Op  in  2  instruction [27:26], taken from the instruction register.
- Funct  in  6  instruction [25:20]: I, cmd[3:0], S/L.
- Rd  in  4  instruction [15:12].
- CondEx  in  1  condition passed, from the conditional logic.
- MemReady  in  1  memory access complete; present only with MC_MEM_WAIT_EN.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemW  out  1  memory write, qualified by CondEx.
- IRWrite  out  1  instruction register enable.
- RegW  out  1  register-file write, qualified by CondEx.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  0 = RD1, 1 = PC.
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  00 = DP imm8, 01 = LDR/STR imm12, 10 = branch imm24.
- RegSrc  out  2  [0] = PC as Rn (branch), [1] = Rd as Rm (STR).
- ALUControl  out  3  000 = ADD, 001 = SUB, 010 = EOR, 011 = ROR, 100 = MOV.
- FlagW  out  2  [1] = NZ write, [0] = CV write; already CondEx-qualified.
- Illegal  out  1  one-cycle pulse in DECODE when Op = 11.

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.

Transitions:
- FETCH→DECODE.
- DECODE→MEMADR if Op = 01; EXECI if Op = 00 and Funct[5] = 1; EXECR if Op = 00 and Funct[5] = 0; BRANCH if Op = 10; FETCH with Illegal = 1 if Op = 11.
- MEMADR→MEMRD if Funct[0] = 1, else MEMWR.
- MEMRD→MEMWB.
- MEMWB, MEMWR, BRANCH→FETCH.
- EXECR/EXECI→FETCH if cmd = 1010 (CMP, no writeback), else ALUWB.
- ALUWB→FETCH.
- Any unencoded state→FETCH.

Per-state outputs (unlisted outputs = 0; ALUControl = ADD outside EXEC):
- FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10, PCWrite = 1 (unconditional).
- DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10.
- MEMADR: ALUSrcA = 0, ALUSrcB = 01, ImmSrc = 01.
- MEMRD: AdrSrc = 1.
- MEMWB: ResultSrc = 01, RegW = CondEx.
- MEMWR: AdrSrc = 1, MemW = CondEx, RegSrc = 10.
- EXECR: ALUSrcB = 00. EXECI: ALUSrcB = 01, ImmSrc = 00.
  - In both, ALUControl comes from cmd: 0100 = ADD, 0010 = SUB, 1010 = SUB, 0001 = EOR, 1101 with I = MOV, 1101 without I = ROR; other cmd values give ADD and suppress the writeback (treated like CMP).
  - FlagW[1] = S & CondEx; FlagW[0] = S & CondEx & (ADD or SUB).
- ALUWB: ResultSrc = 00, RegW = CondEx.
- BRANCH: ALUSrcA = 0, ALUSrcB = 01, ImmSrc = 10, RegSrc = 01, ResultSrc = 10, PCWrite = CondEx.

PC writeback rules:
- In MEMWB and ALUWB with Rd = 1111, PCWrite = CondEx as well.
- A condition-failed instruction still walks the full state path but performs no writes.

## Timing
- Outputs are combinational (Moore) from the registered state plus the IR fields and CondEx.
- Cycle counts: DP = 4, CMP = 3, LDR = 5, STR = 4, B = 3, illegal = 2.
- While reset is high: state = FETCH and PCWrite, IRWrite, RegW, MemW, FlagW and Illegal are forced to 0; the mux selects show their FETCH values.
- Deasserting reset gives a fetch on the first rising edge.
- Reset asserted mid-instruction abandons it immediately; no partial writeback occurs after the reset edge.

## Configuration
- MC_MEM_WAIT_EN defined: the MemReady port exists.
  - FETCH, MEMRD and MEMWR hold (no transition) while MemReady = 0.
  - In FETCH, PCWrite and IRWrite assert only in the cycle where MemReady = 1.
  - MemW stays asserted through every MEMWR wait cycle.
- MC_MEM_WAIT_EN undefined: no MemReady port; memory is single-cycle and the cycle counts above are exact.

## Structure
- Package mc_pkg holds:
  - the state enum (4-bit);
  - ALUControl codes;
  - ResultSrc, ALUSrcB and ImmSrc encodings;
  - the cmd constants ADD, SUB, CMP, EOR and MOV/ROR.
- One sub-module, mc_alu_dec: combinational mapping of Funct → ALUControl, FlagW (pre-qualification) and NoWrite.
- The state register and next-state/output logic live in multicycle_ctrl.

## Test plan
- ADD R1, R2, R3 (Op = 00, Funct = 001000, CondEx = 1) → states F, D, EXECR, ALUWB; ALUControl = 000 in EXECR; RegW = 1 only in ALUWB.
- SUBS immediate (Funct = 100101) → EXECI with ALUSrcB = 01, FlagW = 11; CMP (Funct = 110101) → FlagW = 11 and returns to FETCH after 3 cycles with no RegW.
- LDR (Op = 01, Funct[0] = 1) → 5 cycles, AdrSrc = 1 in MEMRD, ResultSrc = 01 with RegW = 1 in MEMWB; repeat with CondEx = 0 → no RegW.
- B with CondEx = 1 → PCWrite = 1 in BRANCH; with CondEx = 0 → PCWrite = 0; ALU write with Rd = 1111 → PCWrite = 1 in ALUWB.
- Op = 11 → Illegal pulse in DECODE, next state FETCH, no writes; reset asserted in MEMWR → MemW drops the same cycle and state = FETCH.
- With MC_MEM_WAIT_EN: MemReady held 0 for 3 cycles in FETCH → IRWrite/PCWrite stay 0, then pulse once when MemReady = 1.
